// File: rtl/rng_pkg.sv
// ============================================================================
// Module      : rng_pkg
// Description : Shared FSM encoding and default LFSR constants for the RNG.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } rng_state_t;

    // Maximal-length Galois masks for the commonly used widths
    localparam logic [7:0]  c_TAPS_W8      = 8'hB8;
    localparam logic [15:0] c_TAPS_W16     = 16'hB400;
    localparam logic [31:0] c_TAPS_W32     = 32'hA300_0000;
    localparam logic [15:0] c_SEED_DEFAULT = 16'hACE1;

endpackage

`default_nettype wire

// File: rtl/lfsr_rng_gen_if.sv
// ============================================================================
// Module      : lfsr_rng_gen_if
// Description : Request/response handshake for ranged random draws.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lfsr_rng_gen_if #(
    parameter int OUT_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [OUT_W-1:0] req_bound;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [OUT_W-1:0] rsp_data;

    modport master (
        output req_valid, req_bound, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_bound, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

`default_nettype wire

// File: rtl/lfsr_core.sv
// ============================================================================
// Module      : lfsr_core
// Description : Galois LFSR state register with enable, seed load and zero guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_core
    import rng_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(c_TAPS_W16),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(c_SEED_DEFAULT)
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              en,
    input  wire              seed_load,
    input  wire  [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] raw_out
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_seed;

    assign w_step = r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);
    // An all-zero state would lock the LFSR, so a zero load falls back to SEED
    assign w_seed = (seed_in == '0) ? SEED : seed_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEED;
        end else if (seed_load) begin
            r_state <= w_seed;
        end else if (en) begin
            r_state <= w_step;
        end
    end

    assign raw_out = r_state;

endmodule

`default_nettype wire

// File: rtl/lfsr_rng_gen.sv
// ============================================================================
// Module      : lfsr_rng_gen
// Description : LFSR RNG with bounded rejection sampling behind a handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_rng_gen
    import rng_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               OUT_W     = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(c_TAPS_W16),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(c_SEED_DEFAULT),
    parameter int               MAX_TRIES = 8
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              en,
    input  wire              seed_load,
    input  wire  [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] raw_out,
    lfsr_rng_gen_if.slave    bus
);

    localparam int                c_TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [c_TRY_W-1:0] c_LAST_TRY = c_TRY_W'(MAX_TRIES - 1);

    // Smallest 2^k-1 covering b-1; b==0 wraps to all-ones (full range)
    function automatic logic [OUT_W-1:0] range_mask(input logic [OUT_W-1:0] b);
        logic [OUT_W-1:0] v;
        v = b - OUT_W'(1);
        for (int i = 1; i < OUT_W; i++) begin
            v = v | (v >> i);
        end
        return v;
    endfunction

    rng_state_t       r_fsm;
    logic [OUT_W-1:0] r_bound;
    logic [OUT_W-1:0] r_mask;
    logic [c_TRY_W-1:0] r_tries;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [OUT_W-1:0] r_rsp_data;

    logic [OUT_W-1:0] w_cand;
    logic             w_hit;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .raw_out   (raw_out)
    );

    assign w_cand = raw_out[OUT_W-1:0] & r_mask;
    assign w_hit  = (r_bound == '0) || (w_cand < r_bound);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm       <= IDLE;
            r_bound     <= '0;
            r_mask      <= '0;
            r_tries     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_bound     <= bus.req_bound;
                        r_mask      <= range_mask(bus.req_bound);
                        r_tries     <= '0;
                        r_req_ready <= 1'b0;
                        r_fsm       <= DRAW;
                    end
                end
                DRAW: begin
                    if (w_hit) begin
                        r_rsp_data  <= w_cand;
                        r_rsp_valid <= 1'b1;
                        r_fsm       <= DONE;
                    end else if (r_tries == c_LAST_TRY) begin
                        // Mask < 2*bound, so one subtraction lands in range
                        r_rsp_data  <= w_cand - r_bound;
                        r_rsp_valid <= 1'b1;
                        r_fsm       <= DONE;
                    end else begin
                        r_tries <= r_tries + c_TRY_W'(1);
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_fsm       <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_fsm       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

endmodule

`default_nettype wire
